// File: rtl/sha_msg_schedule_buffer.sv
// sha_msg_schedule_buffer
// Masked SHA-512 message-schedule window: holds W[t-16..t-1] as D-share words,
// exposes the taps needed to compute W[t], and streams W[0..79] downstream.
// Shares are bit-interleaved (bit i of share j at index i*D+j); words are only
// moved between registers, never combined, so no share mixing can occur here.
// Optional feature macro: SHA_SCHED_CLEAR_EN adds a CLEAR cycle after W[79] is
// consumed that zeroes the window and the output word before done pulses.
module sha_msg_schedule_buffer #(
   parameter int D      = 2,
   parameter int ROUNDS = 80
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_start,
   input  logic            i_in_valid,
   output logic            o_in_ready,
   input  logic [D*64-1:0] i_in_word,
   output logic [D*64-1:0] o_tap_w2,
   output logic [D*64-1:0] o_tap_w7,
   output logic [D*64-1:0] o_tap_w15,
   output logic [D*64-1:0] o_tap_w16,
   input  logic            i_nw_valid,
   output logic            o_nw_ready,
   input  logic [D*64-1:0] i_nw_word,
   output logic            o_wt_valid,
   input  logic            i_wt_ready,
   output logic [D*64-1:0] o_wt_word,
   output logic [6:0]      o_wt_idx,
   output logic            o_busy,
   output logic            o_done
);

   localparam int         W         = D * 64;
   localparam logic [6:0] LAST_LOAD = 7'd15;
   localparam logic [6:0] LAST_T    = 7'(ROUNDS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_EXPAND = 3'd2,
      S_DRAIN  = 3'd3,
      S_CLEAR  = 3'd4
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [6:0]     r_t;
   logic [W-1:0]   r_buf [16];
   logic [W-1:0]   r_wt_word;
   logic [6:0]     r_wt_idx;
   logic           r_wt_valid;
   logic           r_done;
   logic           w_done_nxt;

   logic           w_slot_free;
   logic           w_in_acc;
   logic           w_nw_acc;
   logic           w_acc;
   logic           w_consume;
   logic           w_start_go;
   logic [W-1:0]   w_word;

   // Handshake decode: a new word may enter only when the output register is free.
   assign w_slot_free = !r_wt_valid || i_wt_ready;
   assign w_in_acc    = (r_state == S_LOAD)   && i_in_valid && w_slot_free;
   assign w_nw_acc    = (r_state == S_EXPAND) && i_nw_valid && w_slot_free;
   assign w_acc       = w_in_acc || w_nw_acc;
   assign w_word      = w_in_acc ? i_in_word : i_nw_word;
   assign w_consume   = r_wt_valid && i_wt_ready;
   // A start arriving while done is still pulsing belongs to the finished block and is dropped.
   assign w_start_go  = (r_state == S_IDLE) && i_start && !r_done;

   // State register.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and done-pulse decode.
   always_comb begin
      w_state_nxt = r_state;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start_go) w_state_nxt = S_LOAD;
         end
         S_LOAD: begin
            if (w_in_acc && (r_t == LAST_LOAD)) w_state_nxt = S_EXPAND;
         end
         S_EXPAND: begin
            if (w_nw_acc && (r_t == LAST_T)) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (w_consume) begin
`ifdef SHA_SCHED_CLEAR_EN
               w_state_nxt = S_CLEAR;
`else
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
`endif
            end
         end
         S_CLEAR: begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Window shift, output word register, round counter and done flag.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int k = 0; k < 16; k++) r_buf[k] <= '0;
         r_wt_word  <= '0;
         r_wt_idx   <= '0;
         r_wt_valid <= 1'b0;
         r_t        <= '0;
         r_done     <= 1'b0;
      end else begin
         if (w_start_go) r_t <= '0;
         if (w_acc) begin
            for (int k = 0; k < 15; k++) r_buf[k] <= r_buf[k+1];
            r_buf[15]  <= w_word;
            r_wt_word  <= w_word;
            r_wt_idx   <= r_t;
            r_wt_valid <= 1'b1;
            r_t        <= r_t + 7'd1;
         end else if (i_wt_ready) begin
            r_wt_valid <= 1'b0;
         end
`ifdef SHA_SCHED_CLEAR_EN
         // Wipe any share residue once the last word has left.
         if (r_state == S_CLEAR) begin
            for (int k = 0; k < 16; k++) r_buf[k] <= '0;
            r_wt_word <= '0;
         end
`endif
         r_done <= w_done_nxt;
      end
   end

   assign o_tap_w16  = r_buf[0];
   assign o_tap_w15  = r_buf[1];
   assign o_tap_w7   = r_buf[9];
   assign o_tap_w2   = r_buf[14];
   assign o_in_ready = (r_state == S_LOAD)   && w_slot_free;
   assign o_nw_ready = (r_state == S_EXPAND) && w_slot_free;
   assign o_wt_valid = r_wt_valid;
   assign o_wt_word  = r_wt_word;
   assign o_wt_idx   = r_wt_idx;
   assign o_busy     = (r_state != S_IDLE);
   assign o_done     = r_done;

endmodule

// File: tb/tb_sha_msg_schedule_buffer.sv
// tb_sha_msg_schedule_buffer
// Randomized scoreboard bench: the driver records each accepted word in a
// reference array and an expected-output queue; an independent monitor pops
// and compares whenever the consumer takes a word.
module tb_sha_msg_schedule_buffer;

   localparam int D = 2;
   localparam int W = D * 64;
`ifdef SHA_SCHED_CLEAR_EN
   localparam int DONE_LAT = 2;
`else
   localparam int DONE_LAT = 1;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic          nw_valid = 1'b0;
   logic          wt_ready = 1'b0;
   logic [W-1:0]  in_word = '0;
   logic [W-1:0]  nw_word = '0;
   logic          in_ready, nw_ready, wt_valid, busy, done;
   logic [W-1:0]  tap_w2, tap_w7, tap_w15, tap_w16, wt_word;
   logic [6:0]    wt_idx;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int exp_done = -10;

   typedef struct packed {
      logic [W-1:0] word;
      logic [6:0]   idx;
   } exp_t;

   exp_t         sb[$];
   exp_t         mon_e;
   logic [W-1:0] ref_w [80];
   logic         stall_prev = 1'b0;
   logic [W-1:0] stall_word;
   logic [6:0]   stall_idx;

   sha_msg_schedule_buffer #(.D(D), .ROUNDS(80)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
      .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_word(in_word),
      .o_tap_w2(tap_w2), .o_tap_w7(tap_w7), .o_tap_w15(tap_w15), .o_tap_w16(tap_w16),
      .i_nw_valid(nw_valid), .o_nw_ready(nw_ready), .i_nw_word(nw_word),
      .o_wt_valid(wt_valid), .i_wt_ready(wt_ready), .o_wt_word(wt_word),
      .o_wt_idx(wt_idx), .o_busy(busy), .o_done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL timeout_%s: no DUT response within cycle budget", name);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   endtask

   // Bit-interleave two 64-bit shares: bit i of share j lands at 2*i+j.
   function automatic logic [W-1:0] mk(input logic [63:0] s1, input logic [63:0] s0);
      logic [W-1:0] r;
      for (int i = 0; i < 64; i++) begin
         r[2*i]   = s0[i];
         r[2*i+1] = s1[i];
      end
      return r;
   endfunction

   function automatic logic [63:0] r64();
      return {$urandom, $urandom};
   endfunction

   // Consumer with random back-pressure.
   initial begin
      forever begin
         @(posedge clk);
         #1 wt_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: output ordering, stall hold, done timing.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            sb.delete();
            stall_prev = 1'b0;
            exp_done   = -10;
         end else begin
            if (stall_prev) begin
               chk("stall_valid", W'(wt_valid), W'(1'b1));
               chk("stall_word", wt_word, stall_word);
               chk("stall_idx", W'(wt_idx), W'(stall_idx));
            end
            if (done || cyc == exp_done) begin
               chk("done_time", W'(done), W'(cyc == exp_done));
               chk("busy_at_done", W'(busy), W'(1'b0));
            end
            if (wt_valid && wt_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_word: got idx %0d, expected no output", wt_idx);
               end else begin
                  mon_e = sb.pop_front();
                  chk("wt_word", wt_word, mon_e.word);
                  chk("wt_idx", W'(wt_idx), W'(mon_e.idx));
                  if (mon_e.idx == 7'd79) exp_done = cyc + DONE_LAT;
               end
            end
            stall_prev = wt_valid && !wt_ready;
            stall_word = wt_word;
            stall_idx  = wt_idx;
         end
      end
   end

   task automatic do_reset();
      @(posedge clk);
      #1 rst_n = 1'b0; in_valid = 1'b0; nw_valid = 1'b0; start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_wt_valid", W'(wt_valid), '0);
      chk("rst_in_ready", W'(in_ready), '0);
      chk("rst_nw_ready", W'(nw_ready), '0);
      chk("rst_busy", W'(busy), '0);
      chk("rst_done", W'(done), '0);
      chk("rst_wt_idx", W'(wt_idx), '0);
      chk("rst_wt_word", wt_word, '0);
      chk("rst_tap_w16", tap_w16, '0);
      chk("rst_tap_w15", tap_w15, '0);
      chk("rst_tap_w7", tap_w7, '0);
      chk("rst_tap_w2", tap_w2, '0);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Run one block; abort_at>=0 applies a reset when that index is reached.
   task automatic run_block(input int abort_at, input bit pat);
      logic [W-1:0] wd;
      exp_t         e;
      int           n;
      bit           rdy;
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int t = 0; t < 80; t++) begin
         if (t == abort_at) begin
            do_reset();
            return;
         end
         if (t < 16 && pat) wd = mk(64'(t), ~64'(t));
         else               wd = mk(r64(), r64());
         ref_w[t] = wd;
         n = $urandom_range(0, 2);
         for (int g = 0; g < n; g++) begin
            // Drive the port that is closed in this phase; it must be ignored.
            if (t < 16) begin
               nw_valid = 1'b1; nw_word = mk(r64(), r64());
            end else begin
               in_valid = 1'b1; in_word = mk(r64(), r64());
               start = ($urandom_range(0, 1) == 1);
            end
            @(posedge clk);
            #1 nw_valid = 1'b0; in_valid = 1'b0; start = 1'b0;
         end
         if (t < 16) begin
            in_valid = 1'b1; in_word = wd;
         end else begin
            nw_valid = 1'b1; nw_word = wd;
         end
         n = 0;
         forever begin
            @(negedge clk);
            rdy = (t < 16) ? in_ready : nw_ready;
            chk("ready_vs_slot", W'(rdy), W'(!wt_valid || wt_ready));
            if (t >= 16) begin
               chk("tap_w16", tap_w16, ref_w[t-16]);
               chk("tap_w15", tap_w15, ref_w[t-15]);
               chk("tap_w7", tap_w7, ref_w[t-7]);
               chk("tap_w2", tap_w2, ref_w[t-2]);
            end
            if (rdy) break;
            n++;
            if (n > 200) timeout("accept");
         end
         e.word = wd;
         e.idx  = 7'(t);
         sb.push_back(e);
         @(posedge clk);
         #1 in_valid = 1'b0; nw_valid = 1'b0;
      end
   endtask

   // Wait for done, poke start on the done cycle, then check the idle state.
   task automatic finish_block();
      int n = 0;
      forever begin
         @(negedge clk);
         if (done) break;
         n++;
         if (n > 400) timeout("done");
      end
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk("idle_busy", W'(busy), '0);
      chk("idle_in_ready", W'(in_ready), '0);
      chk("idle_done", W'(done), '0);
      chk("idle_wt_valid", W'(wt_valid), '0);
`ifdef SHA_SCHED_CLEAR_EN
      chk("end_tap_w16", tap_w16, '0);
      chk("end_tap_w15", tap_w15, '0);
      chk("end_tap_w7", tap_w7, '0);
      chk("end_tap_w2", tap_w2, '0);
      chk("end_wt_word", wt_word, '0);
`else
      chk("end_tap_w16", tap_w16, ref_w[64]);
      chk("end_tap_w15", tap_w15, ref_w[65]);
      chk("end_tap_w7", tap_w7, ref_w[73]);
      chk("end_tap_w2", tap_w2, ref_w[78]);
      chk("end_wt_word", wt_word, ref_w[79]);
`endif
   endtask

   initial begin
      do_reset();
      run_block(-1, 1'b1);
      finish_block();
      run_block(-1, 1'b0);
      finish_block();
      run_block(40, 1'b0);
      run_block(-1, 1'b0);
      finish_block();
      repeat (3) @(negedge clk);
      chk("queue_empty", W'(sb.size()), '0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
